// File: rtl/img_rx_packer.sv
// img_rx_packer: packs UART bytes into pixel words for the image RAM.
// Handles byte order, inter-byte timeout resync and overflow after frame end.
module img_rx_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_W         = 16,
  parameter int PIXEL_COUNT    = 65536,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_done,
  input  logic                        start,
  output logic                        ram_wren,
  output logic [ADDR_W-1:0]           ram_wraddr,
  output logic [8*BYTES_PER_WORD-1:0] ram_wrdata,
  output logic                        write_done,
  output logic                        busy,
  output logic                        resync,
  output logic                        overflow
);

  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW = ADDR_W + 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES_PER_WORD - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(PIXEL_COUNT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RECV, DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic [DW-1:0]     sr_q, sr_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rs_q, rs_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     word;

  always_comb begin
    word = sr_q;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (idx_q == IW'(l)) begin
        word[8*(BIG_ENDIAN ? (BYTES_PER_WORD-1-l) : l) +: 8] = rx_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    wren_d  = 1'b0;
    rs_d    = 1'b0;
    if (start) begin
      state_d = RECV;
      idx_d   = '0;
      cnt_d   = '0;
      to_d    = '0;
      sr_d    = '0;
      ovf_d   = 1'b0;
    end else if (state_q == RECV) begin
      if (rx_done) begin
        to_d = '0;
        if (idx_q == LAST_IDX) begin
          wren_d = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = word;
          idx_d  = '0;
          sr_d   = '0;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_WORD) state_d = DONE;
        end else begin
          sr_d  = word;
          idx_d = idx_q + IW'(1);
        end
      end else if (idx_q != '0) begin
        // stalled partial word: drop it once the idle budget runs out
        if (to_q == TO_LAST) begin
          idx_d = '0;
          sr_d  = '0;
          to_d  = '0;
          rs_d  = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end else begin
        to_d = '0;
      end
    end else if (rx_done) begin
      ovf_d = 1'b1;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d == RECV);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RECV;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      sr_q    <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rs_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sr_q    <= sr_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rs_q    <= rs_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ram_wren   = wren_q;
  assign ram_wraddr = addr_q;
  assign ram_wrdata = data_q;
  assign write_done = done_q;
  assign busy       = busy_q;
  assign resync     = rs_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_img_rx_packer.sv
// tb_img_rx_packer: directed checks of img_rx_packer over four
// parameter sets (endianness, timeout, overflow, frame end).
module tb_img_rx_packer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n;
  logic [7:0] rxd [4];
  logic       rxv [4];
  logic       st  [4];

  int checks = 0;
  int errors = 0;

  logic a_wren, a_done, a_busy, a_rs, a_ovf;
  logic [15:0] a_addr, a_data;
  logic b_wren, b_done, b_busy, b_rs, b_ovf;
  logic [15:0] b_addr, b_data;
  logic c_wren, c_done, c_busy, c_rs, c_ovf;
  logic [15:0] c_addr;
  logic [23:0] c_data;
  logic d_wren, d_done, d_busy, d_rs, d_ovf;
  logic [3:0] d_addr;
  logic [7:0] d_data;

  img_rx_packer #(.BYTES_PER_WORD(2), .ADDR_W(16), .PIXEL_COUNT(4),
    .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rxd[0]), .rx_done(rxv[0]),
    .start(st[0]), .ram_wren(a_wren), .ram_wraddr(a_addr),
    .ram_wrdata(a_data), .write_done(a_done), .busy(a_busy),
    .resync(a_rs), .overflow(a_ovf));

  img_rx_packer #(.BYTES_PER_WORD(2), .ADDR_W(16), .PIXEL_COUNT(2),
    .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(100000)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rxd[1]), .rx_done(rxv[1]),
    .start(st[1]), .ram_wren(b_wren), .ram_wraddr(b_addr),
    .ram_wrdata(b_data), .write_done(b_done), .busy(b_busy),
    .resync(b_rs), .overflow(b_ovf));

  img_rx_packer #(.BYTES_PER_WORD(3), .ADDR_W(16), .PIXEL_COUNT(4),
    .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rxd[2]), .rx_done(rxv[2]),
    .start(st[2]), .ram_wren(c_wren), .ram_wraddr(c_addr),
    .ram_wrdata(c_data), .write_done(c_done), .busy(c_busy),
    .resync(c_rs), .overflow(c_ovf));

  img_rx_packer #(.BYTES_PER_WORD(1), .ADDR_W(4), .PIXEL_COUNT(16),
    .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) u_d (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rxd[3]), .rx_done(rxv[3]),
    .start(st[3]), .ram_wren(d_wren), .ram_wraddr(d_addr),
    .ram_wrdata(d_data), .write_done(d_done), .busy(d_busy),
    .resync(d_rs), .overflow(d_ovf));

  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] b, input logic s);
    @(negedge Clk);
    rxd[i] = b;
    rxv[i] = 1'b1;
    st[i]  = s;
    @(negedge Clk);
    rxv[i] = 1'b0;
    st[i]  = 1'b0;
  endtask

  task automatic arm(input int i);
    @(negedge Clk);
    st[i] = 1'b1;
    @(negedge Clk);
    st[i] = 1'b0;
  endtask

  int rs_cnt, rs_at, wr_cnt;

  initial begin
    tv[0] = '{8'h12, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b1};
    tv[1] = '{8'h34, 1'b1, 16'd0, 16'h1234, 1'b0, 1'b1};
    tv[2] = '{8'h56, 1'b0, 16'd0, 16'h1234, 1'b0, 1'b1};
    tv[3] = '{8'h78, 1'b1, 16'd1, 16'h5678, 1'b0, 1'b1};
    tv[4] = '{8'h9A, 1'b0, 16'd1, 16'h5678, 1'b0, 1'b1};
    tv[5] = '{8'hBC, 1'b1, 16'd2, 16'h9ABC, 1'b0, 1'b1};
    tv[6] = '{8'hDE, 1'b0, 16'd2, 16'h9ABC, 1'b0, 1'b1};
    tv[7] = '{8'hF0, 1'b1, 16'd3, 16'hDEF0, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) begin
      rxd[i] = 8'h00;
      rxv[i] = 1'b0;
      st[i]  = 1'b0;
    end
    Reset_n = 1'b0;
    #12;
    chk("rst_outs_a", {a_wren, a_done, a_busy, a_rs, a_ovf}, 0);
    chk("rst_bus_a", {a_addr, a_data}, 0);
    chk("rst_outs_b", {b_wren, b_done, b_busy, b_rs, b_ovf}, 0);
    chk("rst_bus_b", {b_addr, b_data}, 0);
    chk("rst_outs_c", {c_wren, c_done, c_busy, c_rs, c_ovf}, 0);
    chk("rst_bus_c", {c_addr, c_data}, 0);
    chk("rst_outs_d", {d_wren, d_done, d_busy, d_rs, d_ovf}, 0);
    chk("rst_bus_d", {d_addr, d_data}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("busy_after_rst", a_busy, 1);

    // big-endian frame of four words
    for (int i = 0; i < 8; i++) begin
      send(0, tv[i].b, 1'b0);
      chk($sformatf("a_wren[%0d]", i), a_wren, tv[i].wr);
      chk($sformatf("a_addr[%0d]", i), a_addr, tv[i].addr);
      chk($sformatf("a_data[%0d]", i), a_data, tv[i].data);
      chk($sformatf("a_done[%0d]", i), a_done, tv[i].done);
      chk($sformatf("a_busy[%0d]", i), a_busy, tv[i].busy);
    end

    send(0, 8'h55, 1'b0);
    chk("a_ovf_wren", a_wren, 0);
    chk("a_ovf_set", a_ovf, 1);
    chk("a_ovf_addr", a_addr, 3);
    chk("a_ovf_done", a_done, 1);
    arm(0);
    chk("a_arm_done", a_done, 0);
    chk("a_arm_ovf", a_ovf, 0);
    chk("a_arm_busy", a_busy, 1);
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    chk("a_rearm_wren", a_wren, 1);
    chk("a_rearm_addr", a_addr, 0);
    chk("a_rearm_data", a_data, 16'h0102);

    // start beats a coincident final byte
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b1);
    chk("a_st_drop_wren", a_wren, 0);
    send(0, 8'h33, 1'b0);
    send(0, 8'h44, 1'b0);
    chk("a_st_wren", a_wren, 1);
    chk("a_st_addr", a_addr, 0);
    chk("a_st_data", a_data, 16'h3344);

    // asynchronous reset mid-word
    send(0, 8'h55, 1'b0);
    send(0, 8'h66, 1'b0);
    chk("a_pre_addr", a_addr, 1);
    chk("a_pre_data", a_data, 16'h5566);
    send(0, 8'h77, 1'b0);
    #1 Reset_n = 1'b0;
    #1;
    chk("a_mrst_outs", {a_wren, a_done, a_busy, a_rs, a_ovf}, 0);
    chk("a_mrst_bus", {a_addr, a_data}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    send(0, 8'h88, 1'b0);
    send(0, 8'h99, 1'b0);
    chk("a_post_wren", a_wren, 1);
    chk("a_post_addr", a_addr, 0);
    chk("a_post_data", a_data, 16'h8899);

    // little-endian, two-word frame with overflow
    send(1, 8'h12, 1'b0);
    chk("b_w0_idle", b_wren, 0);
    send(1, 8'h34, 1'b0);
    chk("b_w0_wren", b_wren, 1);
    chk("b_w0_addr", b_addr, 0);
    chk("b_w0_data", b_data, 16'h3412);
    send(1, 8'h56, 1'b0);
    send(1, 8'h78, 1'b0);
    chk("b_w1_wren", b_wren, 1);
    chk("b_w1_addr", b_addr, 1);
    chk("b_w1_data", b_data, 16'h7856);
    chk("b_w1_done", b_done, 1);
    chk("b_w1_busy", b_busy, 0);
    send(1, 8'h9A, 1'b0);
    chk("b_ov_wren0", b_wren, 0);
    chk("b_ov_set", b_ovf, 1);
    send(1, 8'hBC, 1'b0);
    chk("b_ov_wren1", b_wren, 0);
    chk("b_ov_addr", b_addr, 1);
    chk("b_ov_data", b_data, 16'h7856);
    arm(1);
    chk("b_arm_done", b_done, 0);
    chk("b_arm_ovf", b_ovf, 0);
    send(1, 8'h01, 1'b0);
    send(1, 8'h02, 1'b0);
    chk("b_rearm_wren", b_wren, 1);
    chk("b_rearm_addr", b_addr, 0);
    chk("b_rearm_data", b_data, 16'h0201);

    // three-byte words with idle timeout
    send(2, 8'hAA, 1'b0);
    send(2, 8'hBB, 1'b0);
    rs_cnt = 0;
    rs_at  = 0;
    wr_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (c_rs) begin
        rs_cnt++;
        if (rs_at == 0) rs_at = i;
      end
      if (c_wren) wr_cnt++;
    end
    chk("c_rs_count", rs_cnt, 1);
    chk("c_rs_cycle", rs_at, 16);
    chk("c_idle_wr", wr_cnt, 0);
    send(2, 8'h11, 1'b0);
    chk("c_b0_wren", c_wren, 0);
    send(2, 8'h22, 1'b0);
    chk("c_b1_wren", c_wren, 0);
    send(2, 8'h33, 1'b0);
    chk("c_wren", c_wren, 1);
    chk("c_addr", c_addr, 0);
    chk("c_data", c_data, 24'h112233);
    chk("c_busy", c_busy, 1);

    // single-byte words over a 16-word frame
    for (int i = 0; i < 16; i++) begin
      send(3, 8'(i * 3 + 1), 1'b0);
      chk($sformatf("d_wren[%0d]", i), d_wren, 1);
      chk($sformatf("d_addr[%0d]", i), d_addr, i);
      chk($sformatf("d_data[%0d]", i), d_data, i * 3 + 1);
      chk($sformatf("d_done[%0d]", i), d_done, (i == 15) ? 1 : 0);
    end
    send(3, 8'hEE, 1'b0);
    chk("d_ov_wren", d_wren, 0);
    chk("d_ov_addr", d_addr, 15);
    chk("d_ov_set", d_ovf, 1);
    chk("d_no_rs", d_rs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
